// File: rtl/int_log.sv
// Iterative integer logarithm: n = floor(log_x(y)), the largest n with x^n <= y.
// Each COND/ITER pair does one multiply and then a full-width compare.
module int_log #(
  parameter int unsigned W  = 8,
  parameter int unsigned NW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  output logic [NW-1:0] n,
  output logic          done,
  output logic          busy,
  output logic          err
);

  localparam int unsigned PW = 2 * W;

  typedef enum logic [1:0] {S_INIT, S_COND, S_ITER, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_acc, w_acc_nxt;
  logic [W-1:0]  r_x, w_x_nxt;
  logic [W-1:0]  r_y, w_y_nxt;
  logic [NW-1:0] r_cnt, w_cnt_nxt;
  logic          r_eflag, w_eflag_nxt;
  logic [NW-1:0] r_n, w_n_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          r_busy, w_busy_nxt;

  logic [PW-1:0] w_prod;
  logic          w_fits;

  // Full 2W product so that overflow past 2^W never wraps into a false "fits".
  assign w_prod = PW'(r_acc) * PW'(r_x);
  assign w_fits = (w_prod <= {W'(0), r_y});

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    w_eflag_nxt = r_eflag;
    w_n_nxt     = r_n;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;

    unique case (r_state)
      S_INIT: begin
        if (start) begin
          w_cnt_nxt = '0;
          if ((x < W'(2)) || (y == '0)) begin
            w_eflag_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_x_nxt     = x;
            w_y_nxt     = y;
            w_acc_nxt   = W'(1);
            w_eflag_nxt = 1'b0;
            w_state_nxt = S_COND;
          end
        end
      end
      S_COND: begin
        w_state_nxt = w_fits ? S_ITER : S_DONE;
      end
      S_ITER: begin
        // Low W bits are exact: prod <= y_r < 2^W.
        w_acc_nxt   = w_prod[W-1:0];
        w_cnt_nxt   = r_cnt + NW'(1);
        w_state_nxt = S_COND;
      end
      S_DONE: begin
        // First DONE cycle publishes the result; second returns to INIT.
        if (!r_done) begin
          w_n_nxt    = r_cnt;
          w_err_nxt  = r_eflag;
          w_done_nxt = 1'b1;
        end else begin
          w_state_nxt = S_INIT;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase

    w_busy_nxt = (w_state_nxt != S_INIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_acc   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_eflag <= 1'b0;
      r_n     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_cnt   <= w_cnt_nxt;
      r_eflag <= w_eflag_nxt;
      r_n     <= w_n_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign n    = r_n;
  assign done = r_done;
  assign err  = r_err;
  assign busy = r_busy;

endmodule

// File: tb/tb_int_log.sv
// Bench for int_log: directed vector table, hand-built handshake/reset sequences,
// and random operands checked against a repeated-multiplication reference.
module tb_int_log;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic [3:0] n;
  logic       done;
  logic       busy;
  logic       err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int_log #(.W(8), .NW(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x    (x),
    .y    (y),
    .n    (n),
    .done (done),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int vx;
    int vy;
    int en;
    int ee;
    int elat;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: count how many times x can be multiplied in before exceeding y.
  function automatic void model(input int ix, input int iy, output int en, output int ee);
    longint p;
    en = 0;
    ee = 0;
    if (ix < 2 || iy == 0) begin
      ee = 1;
    end else begin
      p = ix;
      while (p <= iy) begin
        en++;
        p = p * ix;
      end
    end
  endfunction

  // One operation; lat is the edge count from the start-sampling edge to done.
  task automatic run_op(input int ix, input int iy, output int on, output int oe,
                        output int lat);
    int busy_ok;
    @(negedge clk);
    x = 8'(ix);
    y = 8'(iy);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    busy_ok = 1;
    for (int e = 1; e <= 64; e++) begin
      @(posedge clk);
      #1;
      if (!busy) busy_ok = 0;
      if (done) begin
        lat = e;
        break;
      end
    end
    on = int'(n);
    oe = int'(err);
    chk("done_seen", int'(lat > 0), 1);
    chk("busy_span", busy_ok, 1);
    @(posedge clk);
    #1;
    chk("done_pulse_width", int'(done), 0);
    chk("busy_release", int'(busy), 0);
  endtask

  vec_t vecs[$];

  initial begin
    int gn, ge, gl, en, ee, rx, ry;
    int d1, d2, n1, n2;

    vecs.push_back('{3,   80,  3, 0, 8});
    vecs.push_back('{16,  255, 1, 0, 4});
    vecs.push_back('{2,   255, 7, 0, 16});
    vecs.push_back('{10,  9,   0, 0, 2});
    vecs.push_back('{1,   50,  0, 1, 1});
    vecs.push_back('{5,   0,   0, 1, 1});
    vecs.push_back('{2,   8,   3, 0, 8});
    vecs.push_back('{255, 255, 1, 0, 4});
    vecs.push_back('{0,   0,   0, 1, 1});
    vecs.push_back('{15,  225, 2, 0, 6});

    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_n", int'(n), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    #19 rst = 1'b1;

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].vx, vecs[i].vy, gn, ge, gl);
      chk($sformatf("vec%0d_n", i), gn, vecs[i].en);
      chk($sformatf("vec%0d_err", i), ge, vecs[i].ee);
      chk($sformatf("vec%0d_lat", i), gl, vecs[i].elat);
    end

    // A start pulse while busy must be ignored
    @(negedge clk);
    x = 8'd2; y = 8'd255; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    gl = -1;
    for (int e = 1; e <= 64; e++) begin
      @(posedge clk);
      #1;
      if (e == 4) begin
        start = 1'b1; x = 8'd3; y = 8'd3;
      end
      if (e == 5) start = 1'b0;
      if (done) begin
        gl = e;
        break;
      end
    end
    chk("busy_start_n", int'(n), 7);
    chk("busy_start_lat", gl, 16);
    @(posedge clk);
    #1;

    // Start held through done: accepted only on the INIT cycle after done
    @(negedge clk);
    x = 8'd2; y = 8'd8; start = 1'b1;
    @(posedge clk);
    #1;
    d1 = -1; d2 = -1; n1 = -1; n2 = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (d1 < 0) begin
          d1 = e; n1 = int'(n);
        end else if (d2 < 0) begin
          d2 = e; n2 = int'(n);
        end
      end
      if (e == 8) begin
        x = 8'd3; y = 8'd9;
      end
      if (e == 10) start = 1'b0;
    end
    chk("hold_first_edge", d1, 8);
    chk("hold_first_n", n1, 3);
    chk("hold_second_edge", d2, 16);
    chk("hold_second_n", n2, 2);
    repeat (4) @(posedge clk);

    // Asynchronous reset mid-operation
    @(negedge clk);
    x = 8'd2; y = 8'd200; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_n", int'(n), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    run_op(4, 64, gn, ge, gl);
    chk("postrst_n", gn, 3);
    chk("postrst_err", ge, 0);
    chk("postrst_lat", gl, 8);

    // Random operands against the reference
    for (int i = 0; i < 150; i++) begin
      rx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
      ry = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      model(rx, ry, en, ee);
      run_op(rx, ry, gn, ge, gl);
      chk($sformatf("rnd x=%0d y=%0d n", rx, ry), gn, en);
      chk($sformatf("rnd x=%0d y=%0d err", rx, ry), ge, ee);
      chk($sformatf("rnd x=%0d y=%0d lat", rx, ry), gl, (ee != 0) ? 1 : 2 * en + 2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/int_log.md
Name: int_log

Overview:
- Multi-cycle integer logarithm unit: the inverse of the team's iterative exponent block (x^n).
- Given base x and value y, it returns n = floor(log_x(y)), the largest n with x^n <= y.
- Uses the same INIT/COND/ITER iterative-multiply FSM style, with one multiply per iteration.
- Sits beside the exponent block on the arithmetic datapath and uses a start/done handshake.

Parameters:
- W, 8, width of base x, value y and the internal accumulator.
- NW, 4, width of result n; must satisfy 2^NW > W-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in INIT.
- x  input  W  base; sampled with start.
- y  input  W  value; sampled with start.
- n  output  NW  result floor(log_x(y)); registered.
- done  output  1  one-cycle pulse: n and err are valid.
- busy  output  1  high in every state except INIT.
- err  output  1  invalid operands (x<2 or y==0); registered.

Behaviour:
- Reset (rst=0, async): state=INIT; n=0, done=0, err=0, busy=0; internal acc, cnt, x_r, y_r cleared.
- Reset mid-operation aborts the calculation immediately and gives no done pulse.
- FSM states: INIT, COND, ITER, DONE.
- INIT:
  - start=0 -> stay in INIT.
  - start=1 and (x<2 or y==0) -> go to DONE with err flag set and cnt=0.
  - Otherwise latch x_r=x, y_r=y, acc=1, cnt=0, clear err, go to COND.
- COND:
  - Form prod = acc*x_r at full 2W width; no truncation before the compare.
  - prod <= {W'b0,y_r} -> go to ITER.
  - Otherwise -> go to DONE.
- ITER: acc <= prod[W-1:0]; cnt <= cnt+1; go to COND.
  - The low W bits are exact here, because prod <= y_r < 2^W.
- DONE:
  - Registered: n <= cnt, err <= error flag, done <= 1.
  - Next cycle: state returns to INIT and done deasserts.
  - done is exactly one cycle wide.
- Latency, counted in rising edges from the edge that samples start to the first cycle done=1:
  - Valid operands with result k: 2k+2.
  - Error case: 1.
- Max result: W-1 (x=2, y=2^W-1); cnt never exceeds W-1, so no counter wrap.
- start while busy=1 is ignored; there is no queuing, and x/y changes during the operation have no effect.
- start asserted in the same cycle that done=1: not accepted, because the FSM is in DONE. It is accepted on the following INIT cycle if still held.
- n and err hold their values after done until the next completion or reset.
- n is not forced to 0 when an operation starts.

Test Plan:
- x=3, y=80, start for 1 cycle -> n=3, err=0, done at edge 8 after start sample (27<=80<81); busy high edges 1-8.
- x=16, y=255 -> n=1, done at edge 4. Checks the 2W-wide compare: prod=256 must not truncate to 0 and loop.
- x=2, y=255 -> n=7, done at edge 16. x=10, y=9 -> n=0, done at edge 2.
- x=1, y=50 -> err=1, n=0, done at edge 1. x=5, y=0 -> err=1, n=0. A following valid op, x=2, y=8 -> err=0, n=3.
- Start x=2, y=255, then pulse start with x=3, y=3 at edge 5 -> second request ignored, result n=7. Hold start high through done -> second op begins on the INIT cycle after done.
- Assert rst low at edge 3 of x=2, y=200 -> n=0, done=0, busy=0 immediately. After release, a new op x=4, y=64 -> n=3.
